// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB boundary bundle: MEM-side beat, flush, WB-side beat and stall counter.
// Handshake: a beat moves when its valid and its ready are both high at a rising
// clock edge; valid never depends on ready, and ReadyM is registered state.
interface mem_wb_skid_stage_if #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 16
);
    logic                              ValidM;
    logic                              ReadyM;
    logic                              RegWriteM;
    logic [1:0]                        ResultSrcM;
    logic [DATA_WIDTH-1:0]             ALUResultM;
    logic [DATA_WIDTH-1:0]             ReadDataM;
    logic [DATA_WIDTH-1:0]             ImmExtM;
    logic [DATA_WIDTH-1:0]             PCPlus4M;
    logic [REGISTER_ADDRESS_WIDTH-1:0] RdM;
    logic                              FlushW;
    logic                              ValidW;
    logic                              ReadyW;
    logic                              RegWriteW;
    logic [REGISTER_ADDRESS_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0]             ResultW;
    logic [CNT_WIDTH-1:0]              StallCountW;

    // Driver side: MEM stage and writeback consumer as seen by the bench/pipeline.
    modport master (
        output ValidM, RegWriteM, ResultSrcM, ALUResultM, ReadDataM, ImmExtM,
               PCPlus4M, RdM, FlushW, ReadyW,
        input  ReadyM, ValidW, RegWriteW, RdW, ResultW, StallCountW
    );

    // The skid stage itself.
    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, ALUResultM, ReadDataM, ImmExtM,
               PCPlus4M, RdM, FlushW, ReadyW,
        output ReadyM, ValidW, RegWriteW, RdW, ResultW, StallCountW
    );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline boundary with a 2-entry skid buffer, synchronous flush,
// writeback result mux and a saturating stall counter.
module mem_wb_skid_stage #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_wb_skid_stage_if.slave  bus,
    output logic [1:0]          state_o
);
    localparam int DW  = DATA_WIDTH;
    localparam int RAW = REGISTER_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic           reg_write;
        logic [1:0]     result_src;
        logic [DW-1:0]  alu_result;
        logic [DW-1:0]  read_data;
        logic [DW-1:0]  imm_ext;
        logic [DW-1:0]  pc_plus4;
        logic [RAW-1:0] rd;
    } beat_t;

    state_t               state_q;
    beat_t                main_q;
    beat_t                skid_q;
    beat_t                beat_in;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic                 main_valid;
    logic                 skid_valid;
    logic                 accept;
    logic                 drain;

    // Occupancy is the state: main is valid in ONE/TWO, skid only in TWO.
    assign main_valid = (state_q != S_EMPTY);
    assign skid_valid = (state_q == S_TWO);

    assign accept = bus.ValidM && !skid_valid;
    assign drain  = main_valid && bus.ReadyW;

    assign beat_in = '{
        reg_write:  bus.RegWriteM,
        result_src: bus.ResultSrcM,
        alu_result: bus.ALUResultM,
        read_data:  bus.ReadDataM,
        imm_ext:    bus.ImmExtM,
        pc_plus4:   bus.PCPlus4M,
        rd:         bus.RdM
    };

    // Stall counter next value: count held-but-not-consumed cycles, stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !bus.ReadyW && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Occupancy FSM with both entries and the stall counter; flush wins over accept/drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (bus.FlushW) begin
                // Data fields are kept so stale main values stay visible.
                state_q <= S_EMPTY;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (accept) begin
                            main_q  <= beat_in;
                            state_q <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (accept && drain) begin
                            main_q <= beat_in;
                        end else if (accept) begin
                            skid_q  <= beat_in;
                            state_q <= S_TWO;
                        end else if (drain) begin
                            state_q <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (drain) begin
                            main_q  <= skid_q;
                            state_q <= S_ONE;
                        end
                    end
                    default: state_q <= S_EMPTY;
                endcase
            end
        end
    end

    // Writeback result mux driven from the main entry only.
    always_comb begin
        bus.ResultW = main_q.alu_result;
        case (main_q.result_src)
            2'b00:   bus.ResultW = main_q.alu_result;
            2'b01:   bus.ResultW = main_q.read_data;
            2'b10:   bus.ResultW = main_q.pc_plus4;
            default: bus.ResultW = main_q.imm_ext;
        endcase
    end

    assign bus.ReadyM      = !skid_valid;
    assign bus.ValidW      = main_valid;
    assign bus.RdW         = main_q.rd;
    // A write to x0 is suppressed here so the register file never sees it.
    assign bus.RegWriteW   = main_valid && main_q.reg_write && (main_q.rd != '0);
    assign bus.StallCountW = stall_cnt_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed scenarios plus random traffic, checked
// against a queue-based model of an in-order 2-deep buffer.
module tb_mem_wb_skid_stage;
    localparam int DW = 32;
    localparam int RAW = 5;
    localparam int CW = 16;

    typedef struct {
        logic           rw;
        logic [1:0]     src;
        logic [DW-1:0]  alu;
        logic [DW-1:0]  rdata;
        logic [DW-1:0]  imm;
        logic [DW-1:0]  pc4;
        logic [RAW-1:0] rd;
    } beat_t;

    logic clk;
    logic rst_n;
    logic [1:0] state_main;
    logic [1:0] state_small;

    mem_wb_skid_stage_if #(.DATA_WIDTH(DW), .REGISTER_ADDRESS_WIDTH(RAW), .CNT_WIDTH(CW)) bus ();
    mem_wb_skid_stage_if #(.DATA_WIDTH(DW), .REGISTER_ADDRESS_WIDTH(RAW), .CNT_WIDTH(4)) bus4 ();

    mem_wb_skid_stage #(.DATA_WIDTH(DW), .REGISTER_ADDRESS_WIDTH(RAW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_o(state_main)
    );
    mem_wb_skid_stage #(.DATA_WIDTH(DW), .REGISTER_ADDRESS_WIDTH(RAW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .state_o(state_small)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    beat_t          model_q[$];
    logic [CW-1:0]  model_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_result(input beat_t b);
        case (b.src)
            2'd0:    return b.alu;
            2'd1:    return b.rdata;
            2'd2:    return b.pc4;
            default: return b.imm;
        endcase
    endfunction

    task automatic drive_beat(input logic v, input beat_t b);
        bus.ValidM     = v;
        bus.RegWriteM  = b.rw;
        bus.ResultSrcM = b.src;
        bus.ALUResultM = b.alu;
        bus.ReadDataM  = b.rdata;
        bus.ImmExtM    = b.imm;
        bus.PCPlus4M   = b.pc4;
        bus.RdM        = b.rd;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.rw    = 1'($urandom_range(0, 1));
        b.src   = 2'($urandom_range(0, 3));
        b.alu   = $urandom;
        b.rdata = $urandom;
        b.imm   = $urandom;
        b.pc4   = $urandom;
        b.rd    = 5'($urandom_range(0, 31));
        return b;
    endfunction

    function automatic beat_t alu_beat(input logic [DW-1:0] v, input logic [RAW-1:0] rd);
        beat_t b;
        b.rw = 1'b1; b.src = 2'd0; b.alu = v; b.rdata = 32'hDEAD0001;
        b.imm = 32'hDEAD0002; b.pc4 = 32'hDEAD0003; b.rd = rd;
        return b;
    endfunction

    // Model: held beats in arrival order; front is what WB sees.
    task automatic model_edge();
        beat_t b;
        logic  do_drain;
        logic  do_accept;
        if (model_q.size() > 0 && !bus.ReadyW && model_cnt != {CW{1'b1}})
            model_cnt = model_cnt + 1'b1;
        if (bus.FlushW) begin
            model_q.delete();
        end else begin
            do_drain  = (model_q.size() > 0) && bus.ReadyW;
            do_accept = bus.ValidM && (model_q.size() < 2);
            b.rw = bus.RegWriteM; b.src = bus.ResultSrcM; b.alu = bus.ALUResultM;
            b.rdata = bus.ReadDataM; b.imm = bus.ImmExtM; b.pc4 = bus.PCPlus4M; b.rd = bus.RdM;
            if (do_drain) void'(model_q.pop_front());
            if (do_accept) model_q.push_back(b);
        end
    endtask

    task automatic check_outputs(input string phase);
        logic exp_rw;
        exp_rw = (model_q.size() > 0) && model_q[0].rw && (model_q[0].rd != 0);
        chk({phase, ".valid_w"}, 64'(bus.ValidW), 64'(model_q.size() > 0));
        chk({phase, ".ready_m"}, 64'(bus.ReadyM), 64'(model_q.size() < 2));
        chk({phase, ".regwrite_w"}, 64'(bus.RegWriteW), 64'(exp_rw));
        chk({phase, ".stall_cnt"}, 64'(bus.StallCountW), 64'(model_cnt));
        if (model_q.size() > 0) begin
            chk({phase, ".result_w"}, 64'(bus.ResultW), 64'(exp_result(model_q[0])));
            chk({phase, ".rd_w"}, 64'(bus.RdW), 64'(model_q[0].rd));
        end
    endtask

    task automatic tick(input string phase);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(phase);
    endtask

    initial begin
        beat_t b;
        beat_t idle;
        idle = alu_beat(32'h0, 5'd0);

        // Reset and idle inputs.
        rst_n = 1'b0;
        drive_beat(1'b0, idle);
        bus.FlushW = 1'b0;
        bus.ReadyW = 1'b1;
        bus4.ValidM = 1'b0; bus4.RegWriteM = 1'b0; bus4.ResultSrcM = 2'd0;
        bus4.ALUResultM = '0; bus4.ReadDataM = '0; bus4.ImmExtM = '0;
        bus4.PCPlus4M = '0; bus4.RdM = '0; bus4.FlushW = 1'b0; bus4.ReadyW = 1'b0;
        model_q.delete();
        model_cnt = '0;
        #13;
        chk("reset.valid_w", 64'(bus.ValidW), 64'd0);
        chk("reset.ready_m", 64'(bus.ReadyM), 64'd1);
        chk("reset.regwrite_w", 64'(bus.RegWriteW), 64'd0);
        chk("reset.rd_w", 64'(bus.RdW), 64'd0);
        chk("reset.result_w", 64'(bus.ResultW), 64'd0);
        chk("reset.stall_cnt", 64'(bus.StallCountW), 64'd0);
        #10 rst_n = 1'b1;
        tick("idle");

        // Streaming ALU results 1..4 with ReadyW held high.
        for (int i = 1; i <= 4; i++) begin
            drive_beat(1'b1, alu_beat(32'(i), 5'(i)));
            tick("stream");
            chk("stream.result_seq", 64'(bus.ResultW), 64'(i));
            chk("stream.ready_m_high", 64'(bus.ReadyM), 64'd1);
        end
        drive_beat(1'b0, idle);
        tick("stream_tail");
        tick("stream_tail");

        // Backpressure: A and B while ReadyW = 0, then release.
        bus.ReadyW = 1'b0;
        drive_beat(1'b1, alu_beat(32'hA, 5'd10));
        tick("bp");
        drive_beat(1'b1, alu_beat(32'hB, 5'd11));
        tick("bp");
        chk("bp.ready_m_low", 64'(bus.ReadyM), 64'd0);
        drive_beat(1'b1, alu_beat(32'hC, 5'd12));
        tick("bp");
        drive_beat(1'b0, idle);
        tick("bp");
        chk("bp.stall_exact", 64'(bus.StallCountW), 64'd3);
        bus.ReadyW = 1'b1;
        tick("bp_release");
        chk("bp.order_b", 64'(bus.ResultW), 64'hB);
        tick("bp_release");
        chk("bp.empty", 64'(bus.ValidW), 64'd0);

        // Immediate to x0: value visible, write suppressed.
        b = alu_beat(32'h0, 5'd0);
        b.src = 2'd3; b.imm = 32'hFFFFF000;
        drive_beat(1'b1, b);
        bus.ReadyW = 1'b0;
        tick("x0");
        chk("x0.result", 64'(bus.ResultW), 64'hFFFFF000);
        chk("x0.regwrite", 64'(bus.RegWriteW), 64'd0);

        // Fill to TWO, then flush with a beat offered in the same cycle.
        drive_beat(1'b1, alu_beat(32'h55, 5'd3));
        tick("fill");
        drive_beat(1'b1, alu_beat(32'h77, 5'd4));
        bus.FlushW = 1'b1;
        tick("flush");
        chk("flush.valid_w", 64'(bus.ValidW), 64'd0);
        chk("flush.ready_m", 64'(bus.ReadyM), 64'd1);
        bus.FlushW = 1'b0;
        drive_beat(1'b0, idle);
        bus.ReadyW = 1'b1;
        tick("post_flush");
        chk("flush.no_ghost", 64'(bus.ValidW), 64'd0);

        // Stall a beat, then pulse reset between clock edges.
        bus.ReadyW = 1'b0;
        drive_beat(1'b1, alu_beat(32'h99, 5'd7));
        tick("pre_reset");
        drive_beat(1'b0, idle);
        tick("pre_reset");
        tick("pre_reset");
        #3 rst_n = 1'b0;
        #1;
        model_q.delete();
        model_cnt = '0;
        chk("async.valid_w", 64'(bus.ValidW), 64'd0);
        chk("async.regwrite_w", 64'(bus.RegWriteW), 64'd0);
        chk("async.stall_cnt", 64'(bus.StallCountW), 64'd0);
        chk("async.ready_m", 64'(bus.ReadyM), 64'd1);
        #2 rst_n = 1'b1;
        tick("post_reset");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive_beat(1'($urandom_range(0, 3) != 0), rand_beat());
            bus.ReadyW = 1'($urandom_range(0, 2) != 0);
            bus.FlushW = ($urandom_range(0, 15) == 0);
            tick("random");
        end
        bus.FlushW = 1'b0;
        drive_beat(1'b0, idle);
        bus.ReadyW = 1'b1;
        tick("drain");
        tick("drain");

        // Saturation on the 4-bit counter instance.
        bus4.ValidM = 1'b1;
        bus4.ALUResultM = 32'h1234;
        tick("sat");
        bus4.ValidM = 1'b0;
        chk("sat.valid", 64'(bus4.ValidW), 64'd1);
        for (int i = 0; i < 5; i++) tick("sat");
        chk("sat.count5", 64'(bus4.StallCountW), 64'd5);
        for (int i = 0; i < 15; i++) tick("sat");
        chk("sat.count_max", 64'(bus4.StallCountW), 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
